alu_serial_port: RTL

//  Word-side adapter for the bit-serial ALU. Accepts parallel operands via valid/ready and streams them
//  LSB-first, NSHIFT bits per beat, onto the ALU's data_in1/data_in2. Collects the ALU's data_out beats
//  and returns the right-aligned result word via valid/ready. Sits between the bus/immediate logic and the ALU.

---
 rtl/alu_serial_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_serial_port.sv
// ============================================================================
// Module   : alu_serial_port
// Brief    : Word-side adapter for the bit-serial ALU. Streams parallel
//            operands LSB-first, NSHIFT bits per beat, and collects the
//            result beats into a right-aligned word.
// Config   : ALU_SERIAL_PORT_SKID_EN decouples the result register from the
//            FSM so a new operand can be accepted while a result is held.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_port #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_pair,
    input  logic [2*REG_BITS-1:0] in_data1,
    input  logic [2*REG_BITS-1:0] in_data2,
    output logic                  serial_valid,
    input  logic                  alu_active,
    input  logic                  alu_op_done,
    output logic [NSHIFT-1:0]     data_in1,
    output logic [NSHIFT-1:0]     data_in2,
    input  logic [NSHIFT-1:0]     data_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*REG_BITS-1:0] res_data,
    output logic                  err
);

    localparam int W      = 2 * REG_BITS;
    localparam int NBEATS = W / NSHIFT;
    localparam int CW     = $clog2(NBEATS) + 1;

    localparam logic [CW-1:0] LIMIT_PAIR   = CW'(NBEATS);
    localparam logic [CW-1:0] LIMIT_SINGLE = CW'(NBEATS / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

`ifdef ALU_SERIAL_PORT_SKID_EN
    localparam state_t DONE_STATE = IDLE;
`else
    localparam state_t DONE_STATE = HOLD;
`endif

    state_t              state;
    logic [W-1:0]        sh1;
    logic [W-1:0]        sh2;
    // The oldest collected beat is never needed once the next beat arrives,
    // so the collector keeps only the upper W-NSHIFT bits.
    logic [W-1:NSHIFT]   col;
    logic                pair;
    logic [CW-1:0]       count;

    logic                beat;
    logic                done;
    logic [CW-1:0]       count_next;
    logic [CW-1:0]       limit;
    logic [W-1:0]        col_next;
    logic [31:0]         shamt;
    logic [W-1:0]        result;

    assign in_ready = (state == IDLE);

`ifdef ALU_SERIAL_PORT_SKID_EN
    assign serial_valid = (state == SHIFT) && !(res_valid && !res_ready);
`else
    assign serial_valid = (state == SHIFT);
`endif

    assign data_in1   = sh1[NSHIFT-1:0];
    assign data_in2   = sh2[NSHIFT-1:0];

    assign beat       = alu_active && serial_valid;
    assign count_next = count + CW'(1);
    assign limit      = pair ? LIMIT_PAIR : LIMIT_SINGLE;
    assign col_next   = {data_out, col[W-1:NSHIFT]};
    assign done       = beat && (alu_op_done || (count_next == limit));
    // Short ops land in the top of the collector; shift them down to bit 0.
    assign shamt      = 32'(NSHIFT) * (32'(NBEATS) - 32'(count_next));
    assign result     = col_next >> shamt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sh1       <= '0;
            sh2       <= '0;
            col       <= '0;
            pair      <= 1'b0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            if (alu_active && !serial_valid) begin
                err <= 1'b1;
            end
`ifdef ALU_SERIAL_PORT_SKID_EN
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh1   <= in_data1;
                        sh2   <= in_data2;
                        pair  <= in_pair;
                        col   <= '0;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        sh1   <= sh1 >> NSHIFT;
                        sh2   <= sh2 >> NSHIFT;
                        col   <= col_next[W-1:NSHIFT];
                        count <= count_next;
                        if (done) begin
                            sh1       <= '0;
                            sh2       <= '0;
                            res_data  <= result;
                            res_valid <= 1'b1;
                            state     <= DONE_STATE;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
